// File: rtl/i2s_tx_if.sv
// i2s_tx sample-pair handshake.
// Producer drives the pair and in_valid; the transmitter returns in_ready.
interface i2s_tx_if #(
  parameter int DATA_W = 24
) ();
  logic [DATA_W-1:0] in_left;
  logic [DATA_W-1:0] in_right;
  logic              in_valid;
  logic              in_ready;

  modport master (
    output in_left,
    output in_right,
    output in_valid,
    input  in_ready
  );

  modport slave (
    input  in_left,
    input  in_right,
    input  in_valid,
    output in_ready
  );
endinterface

// File: rtl/i2s_tx.sv
// I2S master transmitter: SCKI/BCK/LRCK = clk, clk/4, clk/256, MSB-first.
// `define I2S_TX_UNDERRUN_HOLD_EN repeats the last frame on underrun.
module i2s_tx #(
  parameter int DATA_W = 24,
  parameter int CNT_W  = 16
) (
  input  logic             clk,
  input  logic             reset,
  i2s_tx_if.slave          in_if,
  output logic             scki,
  output logic             bck,
  output logic             lrck,
  output logic             dout,
  output logic             frame_tick,
  output logic             underrun,
  output logic [CNT_W-1:0] underrun_cnt
);

  logic [7:0]        p_q, p_d;
  logic [DATA_W-1:0] hold_l_q, hold_l_d;
  logic [DATA_W-1:0] hold_r_q, hold_r_d;
  logic              hold_full_q, hold_full_d;
  logic [DATA_W-1:0] frm_l_q, frm_l_d;
  logic [DATA_W-1:0] frm_r_q, frm_r_d;
  logic              dout_q, dout_d;
  logic              tick_q, tick_d;
  logic              ur_q, ur_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic              wrap;
  logic              accept;
  logic [4:0]        slot_n;
  logic [4:0]        bit_idx;
  logic [DATA_W-1:0] word_n;

  assign wrap            = (p_q == 8'hFF);
  assign in_if.in_ready  = !hold_full_q || wrap;
  assign accept          = in_if.in_valid && in_if.in_ready;

  always_comb begin
    p_d         = p_q + 8'd1;
    hold_l_d    = hold_l_q;
    hold_r_d    = hold_r_q;
    hold_full_d = hold_full_q && !wrap;
    if (accept) begin
      hold_l_d    = in_if.in_left;
      hold_r_d    = in_if.in_right;
      hold_full_d = 1'b1;
    end
  end

  always_comb begin
    frm_l_d = frm_l_q;
    frm_r_d = frm_r_q;
    tick_d  = wrap;
    ur_d    = wrap && !hold_full_q;
    cnt_d   = cnt_q;
    if (wrap) begin
      if (hold_full_q) begin
        frm_l_d = hold_l_q;
        frm_r_d = hold_r_q;
      end else begin
`ifdef I2S_TX_UNDERRUN_HOLD_EN
        frm_l_d = frm_l_q;
        frm_r_d = frm_r_q;
`else
        frm_l_d = '0;
        frm_r_d = '0;
`endif
      end
    end
    if (ur_d && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Next bit is chosen for the slot entered when bck falls.
  always_comb begin
    slot_n  = p_d[6:2];
    word_n  = p_d[7] ? frm_r_q : frm_l_q;
    bit_idx = 5'(DATA_W) - slot_n;
    dout_d  = dout_q;
    if (p_q[1:0] == 2'd3) begin
      dout_d = 1'b0;
      if ((slot_n != 5'd0) && (slot_n <= 5'(DATA_W))) begin
        dout_d = word_n[bit_idx];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      p_q         <= '0;
      hold_l_q    <= '0;
      hold_r_q    <= '0;
      hold_full_q <= 1'b0;
      frm_l_q     <= '0;
      frm_r_q     <= '0;
      dout_q      <= 1'b0;
      tick_q      <= 1'b0;
      ur_q        <= 1'b0;
      cnt_q       <= '0;
    end else begin
      p_q         <= p_d;
      hold_l_q    <= hold_l_d;
      hold_r_q    <= hold_r_d;
      hold_full_q <= hold_full_d;
      frm_l_q     <= frm_l_d;
      frm_r_q     <= frm_r_d;
      dout_q      <= dout_d;
      tick_q      <= tick_d;
      ur_q        <= ur_d;
      cnt_q       <= cnt_d;
    end
  end

  assign scki         = clk;
  assign bck          = p_q[1];
  assign lrck         = p_q[7];
  assign dout         = dout_q;
  assign frame_tick   = tick_q;
  assign underrun     = ur_q;
  assign underrun_cnt = cnt_q;

endmodule

// File: tb/tb_i2s_tx.sv
// Bench for i2s_tx: frame-level reference model of the holding buffer
// and the I2S bit-slot layout, words rebuilt from dout at bck rises.
module tb_i2s_tx;
  localparam int DW = 24;
  localparam int CW = 4;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic scki, bck, lrck, dout, frame_tick, underrun;
  logic [CW-1:0] underrun_cnt;

  i2s_tx_if #(.DATA_W(DW)) bus ();

  i2s_tx #(.DATA_W(DW), .CNT_W(CW)) dut (
    .clk(clk),
    .reset(reset),
    .in_if(bus),
    .scki(scki),
    .bck(bck),
    .lrck(lrck),
    .dout(dout),
    .frame_tick(frame_tick),
    .underrun(underrun),
    .underrun_cnt(underrun_cnt)
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail = 0;

  // Position within the 256-clk frame as the bench understands it.
  logic [7:0] tp;
  always @(posedge clk or posedge reset)
    if (reset) tp <= 8'd0;
    else tp <= tp + 8'd1;

  typedef struct {
    logic [DW-1:0] l;
    logic [DW-1:0] r;
  } pair_t;

  typedef struct {
    int            idx;
    logic [DW-1:0] got_l, got_r, exp_l, exp_r;
    int            pad_err;
    int            ticks, urs, exp_tick, exp_ur;
    logic [CW-1:0] cnt_obs, cnt_exp;
    int            clk_err, rdy_err;
  } rec_t;

  pair_t pend[$];
  rec_t  recs[$];

  logic          bits_a [0:63];
  logic [DW-1:0] m_l, m_r;
  int            m_tick, m_ur, m_cnt;
  int            s_ticks, s_urs, c_err, r_err;
  bit            span_ok;
  bit            exp_rdy;
  int            frame_no = 0;
  pair_t         pp;
  rec_t          rr;

  always @(negedge clk) begin
    if (reset) begin
      pend.delete();
      m_l = '0; m_r = '0;
      m_tick = 0; m_ur = 0; m_cnt = 0;
      span_ok = 1'b0;
    end else begin
      if (tp == 8'd0) begin
        for (int i = 0; i < 64; i++) bits_a[i] = 1'b0;
        s_ticks = 0; s_urs = 0; c_err = 0; r_err = 0;
        span_ok = 1'b1;
      end
      if (bck !== tp[1] || lrck !== tp[7] || scki !== 1'b0) c_err++;
      if (tp[1:0] == 2'd2) bits_a[tp[7:2]] = dout;
      if (frame_tick === 1'b1) begin
        s_ticks++;
        if (tp != 8'd0) c_err++;
      end
      if (underrun === 1'b1) begin
        s_urs++;
        if (tp != 8'd0) c_err++;
      end
      exp_rdy = (pend.size() == 0) || (tp == 8'hFF);
      if (bus.in_ready !== exp_rdy) r_err++;
      if (tp == 8'hFF) begin
        if (span_ok) begin
          rr.idx = frame_no;
          rr.pad_err = 0;
          for (int s = 0; s < 32; s++) begin
            if (s >= 1 && s <= DW) begin
              rr.got_l[DW-s] = bits_a[s];
              rr.got_r[DW-s] = bits_a[32+s];
            end else begin
              if (bits_a[s] !== 1'b0) rr.pad_err++;
              if (bits_a[32+s] !== 1'b0) rr.pad_err++;
            end
          end
          rr.exp_l = m_l; rr.exp_r = m_r;
          rr.ticks = s_ticks; rr.urs = s_urs;
          rr.exp_tick = m_tick; rr.exp_ur = m_ur;
          rr.cnt_obs = underrun_cnt;
          rr.cnt_exp = CW'(m_cnt);
          rr.clk_err = c_err; rr.rdy_err = r_err;
          recs.push_back(rr);
          frame_no++;
        end
        m_tick = 1;
        if (pend.size() > 0) begin
          pp = pend.pop_front();
          m_l = pp.l; m_r = pp.r; m_ur = 0;
        end else begin
          m_ur = 1;
          if (m_cnt < 2**CW - 1) m_cnt++;
`ifndef I2S_TX_UNDERRUN_HOLD_EN
          m_l = '0; m_r = '0;
`endif
        end
      end
      if (bus.in_valid === 1'b1 && exp_rdy) begin
        pp.l = bus.in_left; pp.r = bus.in_right;
        pend.push_back(pp);
      end
    end
  end

  task automatic chk(input string tag, input int idx,
                     input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s frame %0d: got %0h expected %0h", tag, idx, obs, exp);
    end
  endtask

  task automatic wait_ph(input int t);
    int g;
    g = 0;
    do begin
      @(posedge clk); #1;
      g++;
    end while (int'(tp) != t && g < 600);
    chk("wait_ph", t, 32'(tp), 32'(t));
  endtask

  task automatic put(input logic [DW-1:0] l, input logic [DW-1:0] r);
    bus.in_left = l;
    bus.in_right = r;
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic check_frames(input int n);
    rec_t r;
    int g;
    for (int i = 0; i < n; i++) begin
      g = 0;
      while (recs.size() == 0 && g < 400) begin
        @(posedge clk); #1;
        g++;
      end
      chk("frame_timeout", i, 32'(recs.size() > 0), 32'd1);
      if (recs.size() > 0) begin
        r = recs.pop_front();
        chk("left_word", r.idx, 32'(r.got_l), 32'(r.exp_l));
        chk("right_word", r.idx, 32'(r.got_r), 32'(r.exp_r));
        chk("pad_slots", r.idx, 32'(r.pad_err), 32'd0);
        chk("frame_tick", r.idx, 32'(r.ticks), 32'(r.exp_tick));
        chk("underrun", r.idx, 32'(r.urs), 32'(r.exp_ur));
        chk("underrun_cnt", r.idx, 32'(r.cnt_obs), 32'(r.cnt_exp));
        chk("clocks", r.idx, 32'(r.clk_err), 32'd0);
        chk("in_ready", r.idx, 32'(r.rdy_err), 32'd0);
      end
    end
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_bck"}, 0, 32'(bck), 32'd0);
    chk({tag, "_lrck"}, 0, 32'(lrck), 32'd0);
    chk({tag, "_dout"}, 0, 32'(dout), 32'd0);
    chk({tag, "_tick"}, 0, 32'(frame_tick), 32'd0);
    chk({tag, "_ur"}, 0, 32'(underrun), 32'd0);
    chk({tag, "_cnt"}, 0, 32'(underrun_cnt), 32'd0);
    chk({tag, "_ready"}, 0, 32'(bus.in_ready), 32'd1);
  endtask

  logic [DW-1:0] rl, rrv;
  int g2;

  initial begin
    bus.in_left = '0;
    bus.in_right = '0;
    bus.in_valid = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    chk_reset_outs("reset");
    reset = 1'b0;

    // Idle producer: silent frames, one underrun per frame.
    check_frames(4);

    // Single directed pair.
    wait_ph(10);
    put(24'hA55A3C, 24'h123456);
    check_frames(2);

    // Back-pressure: A fills the buffer, B waits for the frame boundary.
    wait_ph(20);
    bus.in_left = 24'h111111;
    bus.in_right = 24'h222222;
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_left = 24'hB0B0B0;
    bus.in_right = 24'h0C0C0C;
    g2 = 0;
    while (tp != 8'hFF && g2 < 300) begin
      if (tp == 8'd100) chk("bp_ready", 100, 32'(bus.in_ready), 32'd0);
      @(posedge clk); #1;
      g2++;
    end
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    check_frames(3);

    // Random pairs with occasional missed frames.
    for (int i = 0; i < 8; i++) begin
      wait_ph($urandom_range(1, 250));
      if ($urandom_range(0, 3) != 0) begin
        rl = DW'($urandom);
        rrv = DW'($urandom);
        put(rl, rrv);
      end
      check_frames(1);
    end

    // Counter saturation.
    check_frames(20);
    chk("cnt_sat", 0, 32'(underrun_cnt), 32'd15);

    // Asynchronous reset mid-left-word with a full holding buffer.
    wait_ph(5);
    put(24'h5A5A5A, 24'h3C3C3C);
    check_frames(1);
    wait_ph(50);
    put(24'h777777, 24'h888888);
    wait_ph(70);
    reset = 1'b1;
    #1;
    chk_reset_outs("midreset");
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    check_frames(3);

    // Single word then starvation: mute or repeat.
    wait_ph(30);
    put(24'h800001, 24'h00C0DE);
    check_frames(4);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end
endmodule
